// File: rtl/sram_load_verify.sv
// SRAM preload / readback-verify engine for one systolic-array bank.
// Streams valid/ready beats into the bank (LOAD) or compares readback against them (VERIFY).
`timescale 1ns/1ps

module sram_load_verify #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 72,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              err_flag,
    output logic [ADDR_W-1:0] first_err_addr
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | accepting beats, one SRAM access per accepted beat
    // DRAIN | VERIFY only: final compare of the last read
    // DONE  | one-cycle done pulse, results held
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   beat_q, beat_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0] sram_d_q, sram_d_d;
    logic [DATA_W-1:0] exp_data_q, exp_data_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;

    logic              accept;
    logic              last_beat;
    logic              mismatch;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] start_addr;

    assign in_ready   = (state_q == S_RUN) && !abort;
    assign accept     = in_ready && in_valid;
    assign last_beat  = (beat_q == len_q - (ADDR_W+1)'(1));
    assign mismatch   = cmp_vld_q && (sram_q != exp_data_q);
    assign next_addr  = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + 1'b1;
    // An out-of-range base is folded back into the bank so no access lands at or above DEPTH.
    assign start_addr = ({1'b0, base_addr} >= DEPTH_W) ? base_addr - DEPTH_W[ADDR_W-1:0] : base_addr;

    always_comb begin
        state_d          = state_q;
        mode_d           = mode_q;
        len_d            = len_q;
        beat_d           = beat_q;
        cur_addr_d       = cur_addr_q;
        sram_d_d         = sram_d_q;
        exp_data_d       = exp_data_q;
        exp_addr_d       = exp_addr_q;
        cmp_vld_d        = 1'b0;
        aborted_d        = aborted_q;
        err_cnt_d        = err_cnt_q;
        first_err_addr_d = first_err_addr_q;

        if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (err_cnt_q == '0) first_err_addr_d = exp_addr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d           = mode;
                    len_d            = length;
                    beat_d           = '0;
                    cur_addr_d       = start_addr;
                    err_cnt_d        = '0;
                    first_err_addr_d = '0;
                    aborted_d        = 1'b0;
                    state_d          = (length == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (accept) begin
                    beat_d     = beat_q + 1'b1;
                    cur_addr_d = next_addr;
                    sram_d_d   = in_data;
                    if (mode_q) begin
                        exp_data_d = in_data;
                        exp_addr_d = cur_addr_q;
                        cmp_vld_d  = 1'b1;
                    end
                    if (last_beat) state_d = mode_q ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (abort) aborted_d = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            mode_q           <= 1'b0;
            len_q            <= '0;
            beat_q           <= '0;
            cur_addr_q       <= '0;
            sram_d_q         <= '0;
            exp_data_q       <= '0;
            exp_addr_q       <= '0;
            cmp_vld_q        <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            aborted_q        <= 1'b0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
        end else begin
            state_q          <= state_d;
            mode_q           <= mode_d;
            len_q            <= len_d;
            beat_q           <= beat_d;
            cur_addr_q       <= cur_addr_d;
            sram_d_q         <= sram_d_d;
            exp_data_q       <= exp_data_d;
            exp_addr_q       <= exp_addr_d;
            cmp_vld_q        <= cmp_vld_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            aborted_q        <= aborted_d;
            err_cnt_q        <= err_cnt_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

    // SRAM port follows the accept combinationally so each beat costs exactly one cycle.
    assign sram_cen       = !accept;
    assign sram_wen       = !accept || mode_q;
    assign sram_addr      = cur_addr_q;
    assign sram_d         = accept ? in_data : sram_d_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign err_cnt        = err_cnt_q;
    assign err_flag       = (err_cnt_q != '0);
    assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_sram_load_verify.sv
// Directed bench for sram_load_verify with a behavioural single-port SRAM model.
`timescale 1ns/1ps

module tb_sram_load_verify;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [6:0]  base_addr = '0;
    logic [7:0]  length = '0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        sram_cen;
    logic        sram_wen;
    logic [6:0]  sram_addr;
    logic [31:0] sram_d;
    logic [31:0] sram_q = '0;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [7:0]  err_cnt;
    logic        err_flag;
    logic [6:0]  first_err_addr;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:127];
    logic [31:0] flip [0:127];

    always #5 clk = ~clk;

    // Reads return stored data XOR a per-address corruption mask.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_addr] <= sram_d;
            else           sram_q <= mem[sram_addr] ^ flip[sram_addr];
        end
    end

    sram_load_verify #(.DATA_W(32), .ADDR_W(7), .DEPTH(72), .ERR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .base_addr(base_addr), .length(length), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_d(sram_d), .sram_q(sram_q), .busy(busy), .done(done),
        .aborted(aborted), .err_cnt(err_cnt), .err_flag(err_flag),
        .first_err_addr(first_err_addr)
    );

    task automatic do_start(input logic m, input logic [6:0] b, input logic [7:0] len);
        @(negedge clk);
        start = 1'b1; mode = m; base_addr = b; length = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || sram_cen !== 1'b1 || sram_wen !== 1'b1 || sram_addr !== 7'd0 ||
            sram_d !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 ||
            err_cnt !== 8'd0 || err_flag !== 1'b0 || first_err_addr !== 7'd0) begin
            bad++;
            $display("FAIL reset_values: rdy=%b cen=%b wen=%b addr=%0d d=%h busy=%b done=%b ab=%b err=%0d flag=%b first=%0d required all idle/zero",
                     in_ready, sram_cen, sram_wen, sram_addr, sram_d, busy, done, aborted, err_cnt, err_flag, first_err_addr);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_load_full();
        int wrong = 0;
        do_start(1'b0, 7'd0, 8'd72);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL load_busy: got %b required 1", busy); end
        for (int i = 0; i < 72; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            #1;
            total++;
            if (sram_cen !== 1'b0 || sram_wen !== 1'b0 || sram_addr !== 7'(i) || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL load_beat%0d: cen=%b wen=%b addr=%0d rdy=%b required 0 0 %0d 1", i, sram_cen, sram_wen, sram_addr, in_ready, i);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || err_cnt !== 8'd0) begin
            bad++; $display("FAIL load_done: done=%b busy=%b err=%0d required 1 0 0", done, busy, err_cnt);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL load_done_width: done=%b required 0", done); end
        for (int i = 0; i < 72; i++) if (mem[i] !== 32'(i)) wrong++;
        total++;
        if (wrong != 0) begin bad++; $display("FAIL load_contents: %0d wrong words required 0", wrong); end
    endtask

    task automatic test_verify_clean();
        int k = 0;
        do_start(1'b1, 7'd0, 8'd72);
        for (int cyc = 0; cyc < 144; cyc++) begin
            if (cyc % 2 == 0) begin
                in_valid = 1'b1; in_data = 32'(k);
                #1;
                total++;
                if (sram_cen !== 1'b0 || sram_wen !== 1'b1 || sram_addr !== 7'(k) || in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL verify_beat%0d: cen=%b wen=%b addr=%0d rdy=%b required 0 1 %0d 1", k, sram_cen, sram_wen, sram_addr, in_ready, k);
                end
                k++;
            end else begin
                in_valid = 1'b0;
                #1;
                total++;
                if (sram_cen !== 1'b1) begin bad++; $display("FAIL verify_idle_cen cyc%0d: got %b required 1", cyc, sram_cen); end
                if (cyc == 143) begin
                    total++;
                    if (in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                        bad++; $display("FAIL verify_drain: rdy=%b busy=%b done=%b required 0 1 0", in_ready, busy, done);
                    end
                end
            end
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1 || err_cnt !== 8'd0 || err_flag !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL verify_clean_done: done=%b err=%0d flag=%b busy=%b required 1 0 0 0", done, err_cnt, err_flag, busy);
        end
    endtask

    task automatic test_verify_errors();
        flip[5] = 32'hDEADBEEF ^ 32'd5;
        flip[9] = 32'h0000_0100;
        do_start(1'b1, 7'd0, 8'd72);
        for (int i = 0; i < 72; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL err_drain: done=%b busy=%b required 0 1", done, busy); end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || err_cnt !== 8'd2 || first_err_addr !== 7'd5 || err_flag !== 1'b1) begin
            bad++; $display("FAIL err_result: done=%b err=%0d first=%0d flag=%b required 1 2 5 1", done, err_cnt, first_err_addr, err_flag);
        end
        repeat (2) @(negedge clk);
        total++;
        if (err_cnt !== 8'd2 || err_flag !== 1'b1 || first_err_addr !== 7'd5) begin
            bad++; $display("FAIL err_hold: err=%0d flag=%b first=%0d required 2 1 5", err_cnt, err_flag, first_err_addr);
        end
        flip[5] = '0;
        flip[9] = '0;
    endtask

    task automatic test_load_wrap();
        logic [6:0] exp_a [4];
        exp_a[0] = 7'd70; exp_a[1] = 7'd71; exp_a[2] = 7'd0; exp_a[3] = 7'd1;
        do_start(1'b0, 7'd70, 8'd4);
        total++;
        if (err_cnt !== 8'd0 || err_flag !== 1'b0) begin bad++; $display("FAIL wrap_err_clear: err=%0d flag=%b required 0 0", err_cnt, err_flag); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'hA000 + 32'(i);
            #1;
            total++;
            if (sram_cen !== 1'b0 || sram_wen !== 1'b0 || sram_addr !== exp_a[i]) begin
                bad++; $display("FAIL wrap_beat%0d: cen=%b wen=%b addr=%0d required 0 0 %0d", i, sram_cen, sram_wen, sram_addr, exp_a[i]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL wrap_done: got %b required 1", done); end
        total++;
        if (mem[70] !== 32'hA000 || mem[71] !== 32'hA001 || mem[0] !== 32'hA002 || mem[1] !== 32'hA003) begin
            bad++; $display("FAIL wrap_contents: %h %h %h %h required a000 a001 a002 a003", mem[70], mem[71], mem[0], mem[1]);
        end
    endtask

    task automatic test_len_zero();
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base_addr = 7'd3; length = 8'd0;
        #1;
        total++;
        if (sram_cen !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_start: cen=%b busy=%b required 1 0", sram_cen, busy); end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || sram_cen !== 1'b1) begin
            bad++; $display("FAIL zero_done: done=%b busy=%b cen=%b required 1 0 1", done, busy, sram_cen);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || sram_cen !== 1'b1) begin
            bad++; $display("FAIL zero_after: done=%b busy=%b cen=%b required 0 0 1", done, busy, sram_cen);
        end
    endtask

    task automatic test_abort();
        flip[12] = 32'h0000_0001;
        do_start(1'b1, 7'd10, 8'd10);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'd10 + 32'(i);
            if (i == 1) begin start = 1'b1; mode = 1'b0; length = 8'd0; end
            #1;
            total++;
            if (sram_addr !== 7'(10 + i) || busy !== 1'b1 || sram_cen !== 1'b0) begin
                bad++; $display("FAIL abort_beat%0d: addr=%0d busy=%b cen=%b required %0d 1 0", i, sram_addr, busy, sram_cen, 10 + i);
            end
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b1; in_data = 32'd13; abort = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0 || sram_cen !== 1'b1) begin bad++; $display("FAIL abort_block: rdy=%b cen=%b required 0 1", in_ready, sram_cen); end
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        total++;
        if (done !== 1'b1 || aborted !== 1'b1 || err_cnt !== 8'd1 || first_err_addr !== 7'd12 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_result: done=%b ab=%b err=%0d first=%0d busy=%b required 1 1 1 12 0",
                            done, aborted, err_cnt, first_err_addr, busy);
        end
        flip[12] = '0;
    endtask

    task automatic test_reset_mid();
        do_start(1'b0, 7'd20, 8'd8);
        in_valid = 1'b1; in_data = 32'h5555;
        @(negedge clk);
        in_data = 32'h6666;
        #1;
        total++;
        if (sram_cen !== 1'b0 || sram_addr !== 7'd21) begin bad++; $display("FAIL rstmid_pre: cen=%b addr=%0d required 0 21", sram_cen, sram_addr); end
        reset_n = 1'b0;
        #1;
        total++;
        if (sram_cen !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sram_addr !== 7'd0 || aborted !== 1'b0) begin
            bad++; $display("FAIL rstmid_outputs: cen=%b rdy=%b busy=%b done=%b addr=%0d ab=%b required 1 0 0 0 0 0",
                            sram_cen, in_ready, busy, done, sram_addr, aborted);
        end
        @(negedge clk);
        reset_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || sram_cen !== 1'b1) begin
            bad++; $display("FAIL rstmid_after: done=%b busy=%b cen=%b required 0 0 1", done, busy, sram_cen);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) flip[i] = '0;
        test_reset();
        test_load_full();
        test_verify_clean();
        test_verify_errors();
        test_load_wrap();
        test_len_zero();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_load_verify.md
Name: sram_load_verify

Overview:
- Parametrised SRAM preload/readback-verify engine for the systolic-array core.
- Streams words from a valid/ready source into one single-port SRAM bank (weight, activation or output).
- In verify mode, reads the bank back, compares each word against the streamed expected data, and reports an error count and the first failing address.
- One instance per bank (W, ACT, OP); it is the hardware replacement for bench-driven load-and-check sequencing.

Parameters:
- DATA_W, 32, SRAM word width (128 for the output bank).
- ADDR_W, 7, SRAM address width.
- DEPTH, 72, number of valid words in the bank; addresses wrap modulo DEPTH.
- ERR_W, 8, error counter width; the counter saturates.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = LOAD, 1 = VERIFY; sampled with start
- base_addr  in  ADDR_W  first address; sampled with start
- length  in  ADDR_W+1  number of words; sampled with start
- abort  in  1  terminates the current job
- in_valid  in  1  stream data valid
- in_data  in  DATA_W  write data (LOAD) or expected data (VERIFY)
- in_ready  out  1  engine accepts a beat
- sram_cen  out  1  active-low chip enable
- sram_wen  out  1  active-low write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_d  out  DATA_W  SRAM write data
- sram_q  in  DATA_W  SRAM read data; valid the cycle after a read edge
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle completion pulse
- aborted  out  1  last job ended by abort
- err_cnt  out  ERR_W  mismatches in the last VERIFY job
- err_flag  out  1  err_cnt != 0
- first_err_addr  out  ADDR_W  address of the first mismatch

Behaviour:
- Reset (async, reset_n = 0) values:
  - Outputs: in_ready = 0, sram_cen = 1, sram_wen = 1, sram_addr = 0, sram_d = 0, busy = 0, done = 0, aborted = 0, err_cnt = 0, err_flag = 0, first_err_addr = 0.
  - Internal state: FSM = IDLE, all counters 0.
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE:
  - start = 1 latches mode, base_addr and length, clears err_cnt, first_err_addr and aborted, then moves to RUN.
  - If length == 0, start moves directly to DONE with no SRAM access.
  - start in any other state is ignored.
- RUN:
  - in_ready = 1.
  - A beat is accepted when in_valid & in_ready.
  - The SRAM port is combinational from the accept: sram_cen = 0 only on accept, sram_wen = mode ? 1 : 0, sram_addr = cur_addr, sram_d = in_data.
  - Cycles without an accepted beat drive sram_cen = 1, sram_wen = 1, and sram_d holds its last value.
- Address and beat counting:
  - cur_addr starts at base_addr and increments per beat.
  - cur_addr wraps from DEPTH-1 to 0; it never reaches an address >= DEPTH.
  - A beat counter counts up to length.
- VERIFY pipeline:
  - On accept, register exp_data = in_data, exp_addr = cur_addr and cmp_vld = 1.
  - In the next cycle, compare sram_q with exp_data.
  - On mismatch, err_cnt increments and saturates at 2^ERR_W - 1.
  - On the first mismatch of the job, first_err_addr = exp_addr.
  - Back-to-back beats give one compare per cycle.
- End of RUN:
  - On the accept of the last beat, LOAD goes to DONE.
  - On the accept of the last beat, VERIFY goes to DRAIN, where in_ready = 0 and the final compare is performed; DRAIN then goes to DONE.
- DONE:
  - done = 1 for exactly one cycle, busy = 0, then IDLE.
  - err_cnt, err_flag, first_err_addr and aborted hold until the next accepted start.
- abort:
  - abort = 1 in RUN or DRAIN goes to DONE next cycle with aborted = 1.
  - A beat presented in the same cycle as abort is not accepted (in_ready is forced to 0 in that cycle).
  - A compare already in flight still completes.
  - abort in IDLE or DONE has no effect.
- Reset asserted mid-job immediately returns every output to its reset value; no partial done pulse is generated.
- sram_q is ignored except in the compare cycle.

Test Plan:
1. LOAD, base 0, length 72, continuous in_valid with data = address → 72 write cycles (sram_cen = 0, sram_wen = 0) at addresses 0..71; done pulses 1 cycle after the 72nd accept; err_cnt = 0.
2. VERIFY on the same bank, model SRAM returns the stored data, in_valid toggling every other cycle → no mismatches; err_cnt = 0, err_flag = 0; done asserts after DRAIN.
3. VERIFY with the word at address 5 corrupted to 0xDEADBEEF and the word at address 9 corrupted → err_cnt = 2, first_err_addr = 5, err_flag = 1.
4. LOAD, base 70, length 4, DEPTH 72 → writes go to addresses 70, 71, 0, 1; done pulses; no access to address 72.
5. length = 0 → done pulses on the cycle after start; sram_cen stays 1 throughout; busy never rises.
6. abort after beat 3 of a length-10 VERIFY with one pending mismatch → aborted = 1, err_cnt = 1, done pulses; a start presented during RUN is ignored; reset_n low mid-RUN forces sram_cen = 1 and in_ready = 0 immediately.
